// File: rtl/muldiv_hilo.sv
// muldiv_hilo: HI/LO multiply/divide unit.
// Multiply completes in one compute cycle; divide runs a 32-step restoring
// shift-subtract. Signed ops work on magnitudes and fix signs at the end.
// HI/LO also take direct mthi/mtlo writes; a result write overrides them.
module muldiv_hilo (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        cancel,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] hi_wdata,
  input  logic [31:0] lo_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Sign-fixup flags captured at accept time.
  typedef struct packed {
    logic neg_q;  // negate product / quotient
    logic neg_r;  // negate remainder (dividend was negative)
    logic dvz;    // divide by zero: force HI=LO=0
  } flags_t;

  state_t      state, state_nx;
  flags_t      flags_q, flags_in;
  logic        accept;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  // Operand A (multiplicand / dividend-quotient shift reg) and B (multiplier / divisor).
  logic [31:0] quo_q, dvs_q, rem_q;
  logic [5:0]  cnt_q;
  logic [31:0] res_hi_q, res_lo_q;
  logic [31:0] hi_q, lo_q;
  logic        busy_q;

  // Multiply datapath.
  logic [63:0] prod_mag, prod;

  // Divide step.
  logic [32:0] shl;
  logic        take;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] quo_fix, rem_fix;
  logic        div_last;

  assign accept = (state == IDLE) && start && !cancel;

  // Accept-cycle operand decode: magnitudes for signed ops.
  always_comb begin
    a_neg          = ~op[0] & src1[31];
    b_neg          = ~op[0] & src2[31];
    a_mag          = a_neg ? (~src1 + 32'd1) : src1;
    b_mag          = b_neg ? (~src2 + 32'd1) : src2;
    flags_in.neg_q = a_neg ^ b_neg;
    flags_in.neg_r = a_neg;
    flags_in.dvz   = (src2 == 32'd0);
  end

  // Product and its signed fixup, evaluated during MUL.
  always_comb begin
    prod_mag = {32'd0, quo_q} * {32'd0, dvs_q};
    prod     = flags_q.neg_q ? (~prod_mag + 64'd1) : prod_mag;
  end

  // One restoring iteration; the final one also produces the signed result.
  always_comb begin
    shl      = {rem_q, quo_q[31]};
    take     = (shl >= {1'b0, dvs_q});
    rem_nx   = take ? (shl[31:0] - dvs_q) : shl[31:0];
    quo_nx   = {quo_q[30:0], take};
    quo_fix  = flags_q.neg_q ? (~quo_nx + 32'd1) : quo_nx;
    rem_fix  = flags_q.neg_r ? (~rem_nx + 32'd1) : rem_nx;
    div_last = (cnt_q == 6'd31);
    if (flags_q.dvz) begin
      quo_fix = 32'd0;
      rem_fix = 32'd0;
    end
  end

  // State register plus registered busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
    end
  end

  // Next-state and done decode; cancel drops any in-flight op without a write.
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = op[1] ? DIV : MUL;
      MUL:  state_nx = cancel ? IDLE : DONE;
      DIV: begin
        if (cancel)        state_nx = IDLE;
        else if (div_last) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        done     = !cancel && !rst;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = busy_q;

  // Operand latch, divide iteration, and staged result.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q  <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else if (accept) begin
      flags_q <= flags_in;
      quo_q   <= a_mag;
      dvs_q   <= b_mag;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else if (state == MUL) begin
      res_hi_q <= prod[63:32];
      res_lo_q <= prod[31:0];
    end else if (state == DIV && !cancel) begin
      quo_q <= quo_nx;
      rem_q <= rem_nx;
      cnt_q <= cnt_q + 6'd1;
      if (div_last) begin
        res_hi_q <= rem_fix;
        res_lo_q <= quo_fix;
      end
    end
  end

  // HI/LO architectural registers: result write beats mthi/mtlo.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      hi_q <= res_hi_q;
      lo_q <= res_lo_q;
    end else begin
      if (hi_wen) hi_q <= hi_wdata;
      if (lo_wen) lo_q <= lo_wdata;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Bench for muldiv_hilo: vector table through a scoreboard queue plus
// hand sequences for cancel, reset mid-op and write-port collisions.
module tb_muldiv_hilo;

  logic        clk = 1'b0;
  logic        rst, start, cancel, hi_wen, lo_wen, busy, done;
  logic [1:0]  op;
  logic [31:0] src1, src2, hi_wdata, lo_wdata, hi_out, lo_out;

  always #5 clk = ~clk;

  muldiv_hilo dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .cancel(cancel), .hi_wen(hi_wen), .lo_wen(lo_wen),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
    int          inj;  // cycle offset for an ignored start, 0 = none
  } vec_t;

  vec_t vecs[14];
  vec_t sb_q[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive a start in the current cycle and record the expectation.
  task automatic issue(input vec_t v);
    start = 1'b1; op = v.op; src1 = v.a; src2 = v.b;
    sb_q.push_back(v);
  endtask

  // From the accept cycle: wait for done, check latency/busy, then HI/LO.
  task automatic finish(input int exp_lat, input int inj);
    int   lat;
    logic bz;
    vec_t e;
    lat = 0; bz = 1'b0;
    do begin
      @(negedge clk); lat++;
      start = (inj != 0 && lat == inj);
      if (start) begin op = 2'b00; src1 = 32'd2; src2 = 32'd3; end
      #1;
      if (!busy) bz = 1'b1;
    end while (!done && lat < 40);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_during_op", 64'(bz), 64'd0);
    @(negedge clk); start = 1'b0; #1;
    e = sb_q.pop_front();
    chk("hi_result", 64'(hi_out), 64'(e.hi));
    chk("lo_result", 64'(lo_out), 64'(e.lo));
    chk("busy_after", 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    issue(v);
    finish(v.lat, v.inj);
  endtask

  initial begin
    vec_t m23;
    logic seen;
    vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, 0};
    vecs[1]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 2, 0};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 5};
    vecs[3]  = '{2'b11, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000000, 33, 0};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 0};
    vecs[5]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       33, 0};
    vecs[6]  = '{2'b10, 32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2, 33, 0};
    vecs[7]  = '{2'b10, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 33, 0};
    vecs[8]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2, 0};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2, 0};
    vecs[10] = '{2'b10, 32'd5,        32'd0,        32'd0,        32'd0,        33, 0};
    vecs[11] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        2, 0};
    vecs[12] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33, 0};
    vecs[13] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33, 0};
    m23      = '{2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        2, 0};

    rst = 1'b1; start = 1'b0; cancel = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    op = 2'b00; src1 = '0; src2 = '0; hi_wdata = '0; lo_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi_out), 64'd0);
    chk("reset_lo", 64'(lo_out), 64'd0);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // start with cancel in IDLE is dropped
    @(negedge clk); start = 1'b1; cancel = 1'b1; op = 2'b00; src1 = 32'd2; src2 = 32'd3;
    @(negedge clk); start = 1'b0; cancel = 1'b0; #1;
    chk("start_cancel_ignored", 64'(busy), 64'd0);

    // cancel at T+10 of a div, new start at T+11
    @(negedge clk); hi_wen = 1'b1; hi_wdata = 32'h11; lo_wen = 1'b1; lo_wdata = 32'h22;
    @(negedge clk); hi_wen = 1'b0; lo_wen = 1'b0; #1;
    chk("mthi", 64'(hi_out), 64'h11);
    chk("mtlo", 64'(lo_out), 64'h22);
    @(negedge clk); start = 1'b1; op = 2'b10; src1 = 32'd100; src2 = 32'd7;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); start = 1'b0; cancel = (c == 10); #1;
      if (done) seen = 1'b1;
    end
    @(negedge clk); cancel = 1'b0;
    issue(m23); #1;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_no_done", 64'(seen), 64'd0);
    chk("cancel_hi_kept", 64'(hi_out), 64'h11);
    chk("cancel_lo_kept", 64'(lo_out), 64'h22);
    finish(2, 0);

    // mthi in the done cycle loses to the result write
    @(negedge clk); issue(m23);
    @(negedge clk); start = 1'b0;
    @(negedge clk); hi_wen = 1'b1; hi_wdata = 32'hAAAA; #1;
    chk("collide_done", 64'(done), 64'd1);
    @(negedge clk); hi_wen = 1'b0; #1;
    m23 = sb_q.pop_front();
    chk("collide_hi", 64'(hi_out), 64'(m23.hi));
    chk("collide_lo", 64'(lo_out), 64'(m23.lo));

    // cancel in DONE suppresses done and the write
    @(negedge clk); hi_wen = 1'b1; hi_wdata = 32'h33; lo_wen = 1'b1; lo_wdata = 32'h44;
    @(negedge clk); hi_wen = 1'b0; lo_wen = 1'b0;
    start = 1'b1; op = 2'b00; src1 = 32'd5; src2 = 32'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk); cancel = 1'b1; #1;
    chk("cancel_done_pulse", 64'(done), 64'd0);
    @(negedge clk); cancel = 1'b0; #1;
    chk("cancel_done_hi", 64'(hi_out), 64'h33);
    chk("cancel_done_lo", 64'(lo_out), 64'h44);
    chk("cancel_done_busy", 64'(busy), 64'd0);

    // rst at T+5 of a div
    @(negedge clk); start = 1'b1; op = 2'b10; src1 = 32'd100; src2 = 32'd7;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); start = 1'b0; rst = (c == 5);
    end
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_hi", 64'(hi_out), 64'd0);
    chk("rst_mid_lo", 64'(lo_out), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("rst_mid_no_done", 64'(seen), 64'd0);
    run_vec(vecs[5]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
